// File: rtl/brainwave_pkg.sv
// Shared definitions for the instruction queue sequencer: opcode map,
// element-wise / activation encodings and FSM state constants.
package brainwave_pkg;

    // Opcode values as they appear in the top bits of an instruction
    localparam int OP_V_RD      = 0;
    localparam int OP_V_WR      = 1;
    localparam int OP_M_RD      = 2;
    localparam int OP_M_WR      = 3;
    localparam int OP_MV_MUL    = 4;
    localparam int OP_VV_ADD    = 5;
    localparam int OP_VV_SUB    = 6;
    localparam int OP_VV_PASS   = 7;
    localparam int OP_VV_MUL    = 8;
    localparam int OP_V_RELU    = 9;
    localparam int OP_V_SIGM    = 10;
    localparam int OP_V_TANH    = 11;
    localparam int OP_END_CHAIN = 12;

    // Element-wise unit operation select
    typedef enum logic [2:0] {
        ELT_ACT    = 3'b000,
        ELT_ADD    = 3'b001,
        ELT_MUL    = 3'b010,
        ELT_BYPASS = 3'b011,
        ELT_SUB    = 3'b100
    } eltwise_op_e;

    // Activation function select, meaningful when the op is ELT_ACT
    typedef enum logic [1:0] {
        ACT_RELU = 2'b00,
        ACT_TANH = 2'b01,
        ACT_SIGM = 2'b10
    } activation_e;

    // Sequencer FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_WAIT_MVU = 2'd1;
    localparam state_t ST_FLUSH    = 2'd2;

endpackage

// File: rtl/instr_fifo.sv
// Instruction queue: power-of-two circular buffer with occupancy count.
// Push is accepted only while not full; pop is ignored while empty.
module instr_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign in_ready = (count < CW'(DEPTH));
    assign do_push  = in_valid && in_ready;
    assign do_pop   = pop && (count != '0);
    assign head     = mem[rd_ptr];

    // Storage write; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_queue_sequencer.sv
// Instruction queue sequencer: buffers incoming instructions, issues one per
// cycle from the queue head and turns each into registered one-cycle enable
// pulses for the VRF/MRF/DRAM/MVU/element-wise units. MV_MUL stalls issue
// until the MVU reports completion; END_CHAIN spends one cycle in FLUSH.
module instr_queue_sequencer
    import brainwave_pkg::*;
#(
    parameter int INSTR_WIDTH  = 24,
    parameter int OPCODE_WIDTH = 4,
    parameter int ADDR_WIDTH   = 10,
    parameter int NUM_VRF      = 4,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [INSTR_WIDTH-1:0]        instr_in,
    input  logic                          instr_valid,
    output logic                          instr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [ADDR_WIDTH-1:0]         dram_addr,
    output logic                          dram_wr_en,
    output logic [NUM_VRF-1:0]            vrf_rd_en,
    output logic [NUM_VRF-1:0]            vrf_wr_en,
    output logic                          mrf_rd_en,
    output logic                          mrf_wr_en,
    output logic                          mvu_start,
    input  logic                          mvu_done,
    output logic [2:0]                    eltwise_op,
    output logic [1:0]                    activation,
    output logic                          eltwise_valid,
    output logic                          chain_active,
    output logic                          chain_end,
    output logic                          err_illegal
);

    state_t state;
    state_t state_next;

    logic [INSTR_WIDTH-1:0]  head_p0;
    logic                    issue_p0;
    logic [OPCODE_WIDTH-1:0] opcode_p0;
    logic [ADDR_WIDTH-1:0]   op1_p0;
    logic [ADDR_WIDTH-1:0]   op2_p0;
    int                      opc_p0;
    logic                    op1_ok_p0;
    logic [NUM_VRF-1:0]      vrf_onehot_p0;

    logic [NUM_VRF-1:0]      vrf_rd_p0;
    logic [NUM_VRF-1:0]      vrf_wr_p0;
    logic                    dram_wr_p0;
    logic                    mrf_rd_p0;
    logic                    mrf_wr_p0;
    logic                    mvu_p0;
    logic                    elt_valid_p0;
    eltwise_op_e             elt_op_p0;
    activation_e             act_p0;
    logic                    addr_upd_p0;
    logic                    act_upd_p0;
    logic                    end_p0;
    logic                    illegal_p0;

    instr_fifo #(
        .WIDTH (INSTR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .in_data  (instr_in),
        .in_valid (instr_valid),
        .in_ready (instr_ready),
        .pop      (issue_p0),
        .head     (head_p0),
        .count    (fifo_count)
    );

    // Issue from the head while idle, or on the very cycle the MVU finishes
    // so the instruction after MV_MUL follows mvu_done without a bubble.
    assign issue_p0 = (fifo_count != '0) &&
                      ((state == ST_IDLE) || ((state == ST_WAIT_MVU) && mvu_done));

    assign opcode_p0 = head_p0[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign op1_p0    = head_p0[2*ADDR_WIDTH-1:ADDR_WIDTH];
    assign op2_p0    = head_p0[ADDR_WIDTH-1:0];
    assign opc_p0    = int'(opcode_p0);
    assign op1_ok_p0 = (int'(op1_p0) < NUM_VRF);

    // One-hot bank select from op1
    always_comb begin
        vrf_onehot_p0 = '0;
        for (int i = 0; i < NUM_VRF; i++) begin
            vrf_onehot_p0[i] = (op1_p0 == ADDR_WIDTH'(i));
        end
    end

    // Decode the head instruction into the enables it would drive if issued
    always_comb begin
        vrf_rd_p0    = '0;
        vrf_wr_p0    = '0;
        dram_wr_p0   = 1'b0;
        mrf_rd_p0    = 1'b0;
        mrf_wr_p0    = 1'b0;
        mvu_p0       = 1'b0;
        elt_valid_p0 = 1'b0;
        elt_op_p0    = ELT_ACT;
        act_p0       = ACT_RELU;
        addr_upd_p0  = 1'b0;
        act_upd_p0   = 1'b0;
        end_p0       = 1'b0;
        illegal_p0   = 1'b0;
        case (opc_p0)
            OP_V_RD: begin
                if (op1_ok_p0) begin
                    vrf_rd_p0   = vrf_onehot_p0;
                    dram_wr_p0  = 1'b1;
                    addr_upd_p0 = 1'b1;
                end else begin
                    illegal_p0  = 1'b1;
                end
            end
            OP_V_WR: begin
                if (op1_ok_p0) begin
                    vrf_wr_p0   = vrf_onehot_p0;
                    addr_upd_p0 = 1'b1;
                end else begin
                    illegal_p0  = 1'b1;
                end
            end
            OP_M_RD: begin
                mrf_rd_p0   = 1'b1;
                addr_upd_p0 = 1'b1;
            end
            OP_M_WR: begin
                mrf_wr_p0   = 1'b1;
                addr_upd_p0 = 1'b1;
            end
            OP_MV_MUL: begin
                mvu_p0      = 1'b1;
                mrf_rd_p0   = 1'b1;
                addr_upd_p0 = 1'b1;
            end
            OP_VV_ADD: begin
                elt_valid_p0 = 1'b1;
                elt_op_p0    = ELT_ADD;
                addr_upd_p0  = 1'b1;
            end
            OP_VV_SUB: begin
                elt_valid_p0 = 1'b1;
                elt_op_p0    = ELT_SUB;
                addr_upd_p0  = 1'b1;
            end
            OP_VV_PASS: begin
                elt_valid_p0 = 1'b1;
                elt_op_p0    = ELT_BYPASS;
                addr_upd_p0  = 1'b1;
            end
            OP_VV_MUL: begin
                elt_valid_p0 = 1'b1;
                elt_op_p0    = ELT_MUL;
                addr_upd_p0  = 1'b1;
            end
            OP_V_RELU: begin
                elt_valid_p0 = 1'b1;
                act_p0       = ACT_RELU;
                act_upd_p0   = 1'b1;
            end
            OP_V_SIGM: begin
                elt_valid_p0 = 1'b1;
                act_p0       = ACT_SIGM;
                act_upd_p0   = 1'b1;
            end
            OP_V_TANH: begin
                elt_valid_p0 = 1'b1;
                act_p0       = ACT_TANH;
                act_upd_p0   = 1'b1;
            end
            OP_END_CHAIN: begin
                end_p0 = 1'b1;
            end
            default: begin
                illegal_p0 = 1'b1;
            end
        endcase
    end

    // Next-state: waits and flushes fall back to IDLE, an issued MV_MUL or
    // END_CHAIN overrides that with its own state.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     state_next = ST_IDLE;
            ST_WAIT_MVU: if (mvu_done) state_next = ST_IDLE;
            ST_FLUSH:    state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
        if (issue_p0 && mvu_p0) begin
            state_next = ST_WAIT_MVU;
        end else if (issue_p0 && end_p0) begin
            state_next = ST_FLUSH;
        end
    end

    // State register; reset abandons any outstanding MVU wait
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---- p0 -> p1: registered unit controls, pulses last one cycle ----
    // Output register: pulses follow the issue edge; selects hold between uses
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dram_addr     <= '0;
            dram_wr_en    <= 1'b0;
            vrf_rd_en     <= '0;
            vrf_wr_en     <= '0;
            mrf_rd_en     <= 1'b0;
            mrf_wr_en     <= 1'b0;
            mvu_start     <= 1'b0;
            eltwise_op    <= '0;
            activation    <= '0;
            eltwise_valid <= 1'b0;
            chain_active  <= 1'b0;
            chain_end     <= 1'b0;
            err_illegal   <= 1'b0;
        end else begin
            dram_wr_en    <= issue_p0 && dram_wr_p0;
            vrf_rd_en     <= issue_p0 ? vrf_rd_p0 : '0;
            vrf_wr_en     <= issue_p0 ? vrf_wr_p0 : '0;
            mrf_rd_en     <= issue_p0 && mrf_rd_p0;
            mrf_wr_en     <= issue_p0 && mrf_wr_p0;
            mvu_start     <= issue_p0 && mvu_p0;
            eltwise_valid <= issue_p0 && elt_valid_p0;
            chain_end     <= issue_p0 && end_p0;
            if (issue_p0 && addr_upd_p0) begin
                dram_addr <= op2_p0;
            end
            if (issue_p0 && elt_valid_p0) begin
                eltwise_op <= elt_op_p0;
            end
            if (issue_p0 && act_upd_p0) begin
                activation <= act_p0;
            end
            if (issue_p0 && illegal_p0) begin
                err_illegal <= 1'b1;
            end
            if (issue_p0 && !illegal_p0) begin
                chain_active <= !end_p0;
            end
        end
    end

endmodule
